// File: rtl/mv_line_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : mv_line_buf_if
//  Description : Access/clear bus between an MV producer and the MV line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mv_line_buf_if #(
    parameter int MV_W   = 16,
    parameter int MV_NUM = 4,
    parameter int ADDR_W = 9
);
    logic                     clr_i;
    logic                     clr_busy_o;
    logic                     ce_i;
    logic                     we_i;
    logic [MV_NUM-1:0]        wmask_i;
    logic [ADDR_W-1:0]        addr_i;
    logic [MV_W*MV_NUM-1:0]   data_i;
    logic [MV_W*MV_NUM-1:0]   data_o;
    logic                     valid_o;

    modport master (
        output clr_i, ce_i, we_i, wmask_i, addr_i, data_i,
        input  clr_busy_o, data_o, valid_o
    );

    modport slave (
        input  clr_i, ce_i, we_i, wmask_i, addr_i, data_i,
        output clr_busy_o, data_o, valid_o
    );
endinterface
`default_nettype wire

// File: rtl/mv_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mv_line_buf
//  Description : Single-port MV line buffer with per-field masked writes,
//                range protection, read-valid strobe and frame-start clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module mv_line_buf #(
    parameter int MV_W   = 16,
    parameter int MV_NUM = 4,
    parameter int DEPTH  = 480,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    mv_line_buf_if.slave      bus
);
    localparam int c_WORD_W = MV_W * MV_NUM;
    localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    localparam logic [ADDR_W:0]    c_DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DEPTH - 1);

    logic [0:0]          r_state;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [c_WORD_W-1:0] r_data;
    logic                r_valid;

    logic                w_idle;
    logic                w_access;
    logic                w_in_range;
    logic                w_rd;
    logic                w_wr;
    logic                w_clr_wr;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_IDX_W-1:0]  w_waddr;
    logic [c_WORD_W-1:0] w_rd_word;

    // A clr_i pulse in IDLE steals the cycle, so any access alongside it is dropped
    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_access   = rst_n & w_idle & ~bus.clr_i & bus.ce_i;
    assign w_in_range = ({1'b0, bus.addr_i} < c_DEPTH_A);
    assign w_rd       = w_access & ~bus.we_i;
    assign w_wr       = w_access & bus.we_i & w_in_range;
    assign w_clr_wr   = rst_n & ~w_idle;
    assign w_idx      = bus.addr_i[c_IDX_W-1:0];
    assign w_waddr    = w_clr_wr ? r_cnt : w_idx;

    // One narrow array per field makes the write mask a plain per-array enable
    for (genvar k = 0; k < MV_NUM; k++) begin : g_field
        logic [MV_W-1:0] r_mem [DEPTH];
        logic            w_fld_we;

        assign w_fld_we = w_clr_wr | (w_wr & bus.wmask_i[k]);

        always_ff @(posedge clk) begin
            if (w_fld_we) begin
                r_mem[w_waddr] <= w_clr_wr ? '0 : bus.data_i[k*MV_W +: MV_W];
            end
        end

        assign w_rd_word[k*MV_W +: MV_W] = r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) begin
                r_data <= w_in_range ? w_rd_word : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.clr_i) begin
                        r_state <= c_ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    if (bus.clr_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.clr_busy_o = (r_state == c_ST_CLEAR);
    assign bus.data_o     = r_data;
    assign bus.valid_o    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mv_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mv_line_buf
//  Description : Directed bench for mv_line_buf against a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mv_line_buf;
    localparam int MV_W   = 16;
    localparam int MV_NUM = 4;
    localparam int DEPTH  = 480;
    localparam int ADDR_W = 9;

    logic clk;
    logic rst_n;

    mv_line_buf_if #(.MV_W(MV_W), .MV_NUM(MV_NUM), .ADDR_W(ADDR_W)) bus ();

    mv_line_buf #(.MV_W(MV_W), .MV_NUM(MV_NUM), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word-level model: memory image, a remaining-clear-cycles count, and the
    // word the buffer must currently be presenting.
    logic [63:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          busy_left = 0;
    logic [63:0] exp_data  = '0;
    bit          exp_known = 1'b1;
    bit          exp_valid = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_left = 0; exp_valid = 1'b0; exp_data = '0; exp_known = 1'b1;
        end else if (busy_left > 0) begin
            m_mem[DEPTH - busy_left]   = '0;
            m_known[DEPTH - busy_left] = 1'b1;
            exp_valid = 1'b0;
            busy_left = bus.clr_i ? DEPTH : busy_left - 1;
        end else if (bus.clr_i) begin
            busy_left = DEPTH; exp_valid = 1'b0;
        end else if (bus.ce_i && bus.we_i) begin
            exp_valid = 1'b0;
            if (int'(bus.addr_i) < DEPTH) begin
                for (int k = 0; k < MV_NUM; k++)
                    if (bus.wmask_i[k]) m_mem[bus.addr_i][k*MV_W +: MV_W] = bus.data_i[k*MV_W +: MV_W];
                if (bus.wmask_i == '1) m_known[bus.addr_i] = 1'b1;
            end
        end else if (bus.ce_i) begin
            exp_valid = 1'b1;
            if (int'(bus.addr_i) < DEPTH) begin
                exp_data = m_mem[bus.addr_i]; exp_known = m_known[bus.addr_i];
            end else begin
                exp_data = '0; exp_known = 1'b1;
            end
        end else begin
            exp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_o", {63'd0, bus.valid_o}, {63'd0, exp_valid});
            chk("clr_busy_o", {63'd0, bus.clr_busy_o}, {63'd0, busy_left > 0});
            if (exp_known) chk("data_o", bus.data_o, exp_data);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [3:0] m);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = ADDR_W'(a); bus.data_i = d; bus.wmask_i = m;
        cyc();
        bus.ce_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic rd(input int a);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = ADDR_W'(a);
        cyc();
        bus.ce_i = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_i = 1'b1;
        cyc();
        bus.clr_i = 1'b0;
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        bus.clr_i = 1'b0; bus.ce_i = 1'b0; bus.we_i = 1'b0;
        bus.wmask_i = '0; bus.addr_i = '0; bus.data_i = '0;
        repeat (3) cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset data_o", bus.data_o, 64'd0);
        chk("reset valid_o", {63'd0, bus.valid_o}, 64'd0);
        chk("reset clr_busy_o", {63'd0, bus.clr_busy_o}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Back-to-back reads after reset
        bus.ce_i = 1'b1; bus.we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin bus.addr_i = ADDR_W'(i); cyc(); end
        bus.ce_i = 1'b0;
        cyc();

        // Masked merge, then an all-zero mask
        wr(5, 64'h4444_3333_2222_1111, 4'b1111);
        wr(5, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101);
        rd(5);
        @(negedge clk); chk("merge addr5", bus.data_o, 64'h4444_BBBB_2222_DDDD);
        wr(5, 64'h0, 4'b0000);
        rd(5);
        @(negedge clk); chk("mask0 addr5", bus.data_o, 64'h4444_BBBB_2222_DDDD);

        // Top in-range address and first out-of-range address
        wr(479, 64'h0123_4567_89AB_CDEF, 4'b1111);
        rd(479);
        @(negedge clk); chk("addr479", bus.data_o, 64'h0123_4567_89AB_CDEF);
        wr(480, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111);
        rd(480);
        @(negedge clk);
        chk("oor data", bus.data_o, 64'd0);
        chk("oor valid", {63'd0, bus.valid_o}, 64'd1);
        rd(479);
        @(negedge clk); chk("addr479 kept", bus.data_o, 64'h0123_4567_89AB_CDEF);

        // Fill everything, then clear while issuing reads
        for (int i = 0; i < DEPTH; i++)
            wr(i, {16'(i + 1), 16'(i * 3 + 7), 16'hA5A5, 16'(i)}, 4'b1111);
        pulse_clr();
        n = 0;
        while (bus.clr_busy_o && n < 2000) begin
            n++;
            bus.ce_i = (n < 10); bus.we_i = 1'b0; bus.addr_i = ADDR_W'(n);
            cyc();
        end
        bus.ce_i = 1'b0;
        chk("clear length", 64'(n), 64'd480);
        rd(0);   @(negedge clk); chk("cleared 0", bus.data_o, 64'd0);
        rd(240); @(negedge clk); chk("cleared 240", bus.data_o, 64'd0);
        rd(479); @(negedge clk); chk("cleared 479", bus.data_o, 64'd0);

        // Restart the clear at busy cycle 100
        pulse_clr();
        n = 0;
        while (bus.clr_busy_o && n < 2000) begin
            n++;
            bus.clr_i = (n == 100);
            cyc();
        end
        bus.clr_i = 1'b0;
        chk("restart length", 64'(n), 64'd580);

        // Reset in the middle of a clear
        wr(10,  64'h1010_1010_1010_1010, 4'b1111);
        wr(300, 64'h3003_0030_0300_3000, 4'b1111);
        pulse_clr();
        n = 0;
        while (bus.clr_busy_o && n < 50) begin
            n++;
            if (n == 50) rst_n = 1'b0;
            cyc();
        end
        chk("rst mid-clear busy", {63'd0, bus.clr_busy_o}, 64'd0);
        rst_n = 1'b1;
        cyc();
        rd(10);  @(negedge clk); chk("addr10 cleared", bus.data_o, 64'd0);
        rd(300); @(negedge clk); chk("addr300 kept", bus.data_o, 64'h3003_0030_0300_3000);
        cyc();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
